// File: rtl/mod107_pp_accumulator.sv
// Modular accumulator for partial-product residues: sums one packet of beats
// modulo MOD and presents one registered result per packet.
module mod107_pp_accumulator #(
  parameter int unsigned MOD   = 107,
  parameter int unsigned W     = 7,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_terms,
  output logic             out_err
);

  localparam int unsigned      SW      = W + 1;
  localparam logic [W-1:0]     MOD_W   = W'(MOD);
  localparam logic [SW-1:0]    MOD_S   = SW'(MOD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {ST_IDLE = 1'b0, ST_ACC = 1'b1} state_t;

  state_t           r_state,     w_state_nxt;
  logic [W-1:0]     r_acc,       w_acc_nxt;
  logic [CNT_W-1:0] r_count,     w_count_nxt;
  logic             r_err,       w_err_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [W-1:0]     r_out_data,  w_out_data_nxt;
  logic [CNT_W-1:0] r_out_terms, w_out_terms_nxt;
  logic             r_out_err,   w_out_err_nxt;

  logic             w_accept;
  logic             w_idle;
  logic             w_flag;
  logic [W-1:0]     w_d;
  logic [W-1:0]     w_base;
  logic [SW-1:0]    w_s;
  logic [W-1:0]     w_r;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_err_acc;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_idle    = (r_state == ST_IDLE);

  // Pre-reduce the beat, then add with a single conditional subtract.
  assign w_flag     = (in_data >= MOD_W);
  assign w_d        = w_flag ? (in_data - MOD_W) : in_data;
  assign w_base     = w_idle ? '0 : r_acc;
  assign w_s        = {1'b0, w_base} + {1'b0, w_d};
  assign w_r        = (w_s >= MOD_S) ? W'(w_s - MOD_S) : w_s[W-1:0];
  assign w_cnt_base = w_idle ? '0 : r_count;
  assign w_cnt_inc  = (w_cnt_base == CNT_MAX) ? CNT_MAX : (w_cnt_base + CNT_W'(1));
  assign w_err_acc  = (w_idle ? 1'b0 : r_err) | w_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_terms <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_count     <= w_count_nxt;
      r_err       <= w_err_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_terms <= w_out_terms_nxt;
      r_out_err   <= w_out_err_nxt;
    end
  end

  // Next-state: a last beat loads the result and reopens the packet; a
  // retiring result and a new load on the same edge keep out_valid high.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_count_nxt     = r_count;
    w_err_nxt       = r_err;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_terms_nxt = r_out_terms;
    w_out_err_nxt   = r_out_err;

    if (r_out_valid && out_ready) begin
      w_out_valid_nxt = 1'b0;
    end

    if (w_accept) begin
      if (in_last) begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = w_r;
        w_out_terms_nxt = w_cnt_inc;
        w_out_err_nxt   = w_err_acc;
        w_state_nxt     = ST_IDLE;
        w_acc_nxt       = '0;
        w_count_nxt     = '0;
        w_err_nxt       = 1'b0;
      end else begin
        w_state_nxt = ST_ACC;
        w_acc_nxt   = w_r;
        w_count_nxt = w_cnt_inc;
        w_err_nxt   = w_err_acc;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_terms = r_out_terms;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_mod107_pp_accumulator.sv
// Directed bench for mod107_pp_accumulator with hand-computed expected results.
module tb_mod107_pp_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic [3:0] out_terms;
  logic       out_err;

  int n_checks;
  int n_fails;

  mod107_pp_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_terms (out_terms),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic beat(input int d, input bit last);
    in_valid = 1'b1;
    in_data  = 7'(d);
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_data  = 7'h55;
    in_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int d, input int t, input int e);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_data"},  int'(out_data),  d);
    chk({tag, "_terms"}, int'(out_terms), t);
    chk({tag, "_err"},   int'(out_err),   e);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data",  int'(out_data),  0);
    chk("rst_terms", int'(out_terms), 0);
    chk("rst_err",   int'(out_err),   0);
    chk("rst_ready", int'(in_ready),  1);

    // 84 + 84 = 168 -> 61
    beat(84, 1'b0);
    chk("p1_mid_valid", int'(out_valid), 0);
    beat(84, 1'b1);
    chk_result("p1", 61, 2, 0);
    step();
    chk("p1_retired", int'(out_valid), 0);

    // 106 + 1 wraps to 0
    beat(106, 1'b0);
    beat(1, 1'b1);
    chk_result("wrap0", 0, 2, 0);

    // 53*3 = 159 -> 52
    beat(53, 1'b0);
    beat(53, 1'b0);
    beat(53, 1'b1);
    chk_result("p53", 52, 3, 0);

    // Out-of-range beat 120 -> 13 with err, next packet clean
    beat(120, 1'b1);
    chk_result("oor", 13, 1, 1);
    beat(5, 1'b1);
    chk_result("after_oor", 5, 1, 0);

    // Back-to-back single-beat packets
    beat(10, 1'b1);
    chk_result("b2b_a", 10, 1, 0);
    beat(20, 1'b1);
    chk_result("b2b_b", 20, 1, 0);
    step();
    chk("b2b_retired", int'(out_valid), 0);

    // Backpressure: result 61 held for 4 cycles while a beat waits
    out_ready = 1'b0;
    beat(84, 1'b0);
    beat(84, 1'b1);
    chk_result("bp_load", 61, 2, 0);
    in_valid = 1'b1;
    in_data  = 7'd99;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      step();
      chk_result("bp_hold", 61, 2, 0);
    end
    out_ready = 1'b1;
    in_data   = 7'd7;
    in_last   = 1'b1;
    #1;
    chk("bp_release_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_result("bp_next", 7, 1, 0);
    step();
    chk("bp_retired", int'(out_valid), 0);

    // Saturation: 20 beats of 1
    for (int i = 0; i < 19; i++) begin
      beat(1, 1'b0);
    end
    beat(1, 1'b1);
    chk_result("sat", 20, 15, 0);
    step();

    // Reset mid-packet discards partial sum
    beat(100, 1'b0);
    beat(100, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data",  int'(out_data),  0);
    beat(3, 1'b1);
    chk_result("post_rst", 3, 1, 0);
    step();
    chk("post_rst_retired", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
